// File: rtl/digit_entry_pkg.sv
// Shared types and helpers for the two-digit BCD entry block: FSM encoding,
// key indices and BCD arithmetic used by the entry datapath.
package digit_entry_pkg;

    typedef enum logic {
        EDIT = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int KEY_INC  = 0;
    localparam int KEY_SEL  = 1;
    localparam int KEY_ENT  = 2;
    localparam int NUM_KEYS = 3;

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/digit_entry_if.sv
// Key/consumer bundle for digit_entry; master is the entry block, slave is
// the side that presses keys and consumes VALUE.
interface digit_entry_if;
    logic [2:0] key_n;
    logic       ready;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       sel;
    logic [6:0] value;
    logic       valid;
    logic       err;

    modport master (
        input  key_n, ready,
        output ones, tens, sel, value, valid, err
    );

    modport slave (
        output key_n, ready,
        input  ones, tens, sel, value, valid, err
    );
endinterface

// File: rtl/digit_entry_key_debounce.sv
// One pushbutton: 2-flop synchronizer, consecutive-cycle debounce and a
// one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [1:0]       fill_reg;
    logic             level_reg, level_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             armed_reg, armed_next;
    logic             press_reg, press_next;
    logic             synced;

    assign synced = sync_reg[1];

    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        if (synced != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = synced;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
        // Arm only once the synchronizer holds real samples showing the key up,
        // so a key held through reset never produces a press.
        armed_next = armed_reg | (fill_reg[1] & synced & level_reg);
        press_next = armed_reg & level_reg & ~level_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b11;
            fill_reg  <= 2'b00;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
            armed_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_n};
            fill_reg  <= {fill_reg[0], 1'b1};
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            armed_reg <= armed_next;
            press_reg <= press_next;
        end
    end

    assign press = press_reg;
endmodule

// File: rtl/digit_entry.sv
// Two-digit BCD entry: three debounced keys edit ONES/TENS, enter offers the
// binary value on a VALID/READY handshake or pulses ERR if it is too small.
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MIN_VALUE       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    digit_entry_if.master bus
);
    logic [NUM_KEYS-1:0] press;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
                .clk   (clk),
                .rst_n (rst_n),
                .key_n (bus.key_n[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    state_t     state_reg, state_next;
    logic [3:0] ones_reg, ones_next;
    logic [3:0] tens_reg, tens_next;
    logic       sel_reg, sel_next;
    logic [6:0] value_reg, value_next;
    logic       valid_reg, valid_next;
    logic       err_reg, err_next;
    logic [6:0] entered;

    assign entered = bcd_to_bin(tens_reg, ones_reg);

    always_comb begin
        state_next = state_reg;
        ones_next  = ones_reg;
        tens_next  = tens_reg;
        sel_next   = sel_reg;
        value_next = value_reg;
        valid_next = valid_reg;
        err_next   = 1'b0;
        case (state_reg)
            EDIT: begin
                // Priority enter > select > increment; lower events are dropped.
                if (press[KEY_ENT]) begin
                    if (int'(entered) >= MIN_VALUE) begin
                        value_next = entered;
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (press[KEY_SEL]) begin
                    sel_next = ~sel_reg;
                end else if (press[KEY_INC]) begin
                    if (sel_reg) tens_next = next_digit(tens_reg);
                    else         ones_next = next_digit(ones_reg);
                end
            end
            HOLD: begin
                if (valid_reg && bus.ready) begin
                    valid_next = 1'b0;
                    state_next = EDIT;
                end
            end
            default: state_next = EDIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EDIT;
            ones_reg  <= '0;
            tens_reg  <= '0;
            sel_reg   <= 1'b0;
            value_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ones_reg  <= ones_next;
            tens_reg  <= tens_next;
            sel_reg   <= sel_next;
            value_reg <= value_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    assign bus.ones  = ones_reg;
    assign bus.tens  = tens_reg;
    assign bus.sel   = sel_reg;
    assign bus.value = value_reg;
    assign bus.valid = valid_reg;
    assign bus.err   = err_reg;
endmodule
